affine_io_sequencer: RTL and testbench

//  Front-end controller for the picoMIPS affine-transform datapath.
//  - Captures operand x, then y, from the switches using the SW8 press/release handshake.
//  - Starts the datapath, waits for completion, then presents results on LED: x' first, y' after the next press.
//  - Sits between the board I/O (SW, LED) and the datapath start/done interface.

---
 rtl/picoMIPS_pkg.sv | 22 ++
 rtl/sw_debounce.sv | 36 +++
 rtl/affine_io_sequencer.sv | 138 +++++++++++++
 tb/tb_affine_io_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/picoMIPS_pkg.sv
// Shared types and constants for the picoMIPS affine-transform front end.
package picoMIPS_pkg;

   localparam int DATA_W = 8;

   typedef logic [DATA_W-1:0] data_t;

   localparam data_t LED_ERR_PATTERN = '1;

   typedef enum logic [3:0] {
      CAP_X,
      HOLD_X,
      CAP_Y,
      HOLD_Y,
      START,
      BUSY,
      SHOW_X,
      SHOW_Y,
      ERR
   } seq_state_t;

endpackage

// File: rtl/sw_debounce.sv
// Synchronises an asynchronous switch and only moves the output level after
// STABLE_CYCLES consecutive identical samples differing from the current level.
module sw_debounce #(
   parameter int STABLE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         cnt_q  <= '0;
         level  <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], din};
         // Any sample matching the current level is a glitch end: restart the count.
         if (sync_q[1] == level) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
            level <= sync_q[1];
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

endmodule

// File: rtl/affine_io_sequencer.sv
// Operand capture / result display sequencer for the picoMIPS datapath; dp_start 1 cycle after rel, LED 1 cycle after dp_done.
// Define DEBOUNCE_EN to filter sw_ack through sw_debounce; otherwise a bare 2-FF synchroniser feeds the edge detector.
module affine_io_sequencer #(
   parameter int DATA_WIDTH      = 8,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int TIMEOUT_CYCLES  = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] sw_data,
   input  logic                  sw_ack,
   output logic [DATA_WIDTH-1:0] dp_x,
   output logic [DATA_WIDTH-1:0] dp_y,
   output logic                  dp_start,
   input  logic                  dp_done,
   input  logic [DATA_WIDTH-1:0] dp_xres,
   input  logic [DATA_WIDTH-1:0] dp_yres,
   output logic [DATA_WIDTH-1:0] LED,
   output logic                  err
);

   import picoMIPS_pkg::*;

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   seq_state_t state_q, state_d;

   logic                  ack_lvl, ack_lvl_q;
   logic                  press, rel;
   logic [TW-1:0]         timer_q, timer_d;
   logic [TW:0]           busy_cnt;
   logic [DATA_WIDTH-1:0] yres_q;
   logic                  cap_x, cap_y, ld_res, show_y, to_err;

`ifdef DEBOUNCE_EN
   sw_debounce #(
      .STABLE_CYCLES(DEBOUNCE_CYCLES)
   ) u_sw_debounce (
      .clk  (clk),
      .reset(reset),
      .din  (sw_ack),
      .level(ack_lvl)
   );
`else
   localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

   logic [1:0] ack_sync_q;

   always_ff @(posedge clk) begin
      if (reset) ack_sync_q <= '0;
      else       ack_sync_q <= {ack_sync_q[0], sw_ack};
   end

   assign ack_lvl = ack_sync_q[1];
`endif

   always_ff @(posedge clk) begin
      if (reset) ack_lvl_q <= 1'b0;
      else       ack_lvl_q <= ack_lvl;
   end

   assign press = ack_lvl & ~ack_lvl_q;
   assign rel   = ~ack_lvl & ack_lvl_q;

   // Number of BUSY cycles elapsed including the current one.
   assign busy_cnt = {1'b0, timer_q} + {{TW{1'b0}}, 1'b1};

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      cap_x    = 1'b0;
      cap_y    = 1'b0;
      ld_res   = 1'b0;
      show_y   = 1'b0;
      to_err   = 1'b0;
      dp_start = 1'b0;
      case (state_q)
         CAP_X:  if (press) begin state_d = HOLD_X; cap_x = 1'b1; end
         HOLD_X: if (rel)   state_d = CAP_Y;
         CAP_Y:  if (press) begin state_d = HOLD_Y; cap_y = 1'b1; end
         HOLD_Y: if (rel)   state_d = START;
         START: begin
            dp_start = 1'b1;
            timer_d  = '0;
            state_d  = BUSY;
         end
         BUSY: begin
            // A completion arriving on the limit cycle still counts as success.
            if (dp_done) begin
               state_d = SHOW_X;
               ld_res  = 1'b1;
            end else if (busy_cnt == (TW+1)'(TIMEOUT_CYCLES)) begin
               state_d = ERR;
               to_err  = 1'b1;
            end else if (timer_q != TW'(TIMEOUT_CYCLES)) begin
               timer_d = timer_q + TW'(1);
            end
         end
         SHOW_X: if (press) begin state_d = SHOW_Y; show_y = 1'b1; end
         SHOW_Y: if (rel)   state_d = CAP_X;
         ERR:    state_d = ERR;
         default: state_d = CAP_X;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= CAP_X;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dp_x   <= '0;
         dp_y   <= '0;
         LED    <= '0;
         yres_q <= '0;
         err    <= 1'b0;
      end else begin
         if (cap_x) dp_x <= sw_data;
         if (cap_y) dp_y <= sw_data;
         if (ld_res) begin
            LED    <= dp_xres;
            yres_q <= dp_yres;
         end
         if (show_y) LED <= yres_q;
         if (to_err) begin
            LED <= DATA_WIDTH'(LED_ERR_PATTERN);
            err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_affine_io_sequencer.sv
// Directed + randomized checks of affine_io_sequencer against a transaction-level model,
// with a stub datapath answering dp_start after 3 cycles.
module tb_affine_io_sequencer;

   localparam int T      = 255;
   localparam int SETTLE = 30;

   logic       clk;
   logic       reset;
   logic [7:0] sw_data;
   logic       sw_ack;
   logic [7:0] dp_x, dp_y, LED;
   logic       dp_start;
   logic       dp_done;
   logic [7:0] dp_xres, dp_yres;
   logic       err;

   logic       stub_en;
   logic       stub_done;
   logic       stray_done;
   int         stub_cnt;

   logic [7:0] res_x, res_y;
   logic [7:0] m_x, m_y, m_led, m_ry;
   logic       m_err;
   int         m_step;
   int         m_starts;
   int         start_cnt;
   int         n_cmp, n_bad;

   affine_io_sequencer #(
      .DATA_WIDTH     (8),
      .DEBOUNCE_CYCLES(16),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .sw_data (sw_data),
      .sw_ack  (sw_ack),
      .dp_x    (dp_x),
      .dp_y    (dp_y),
      .dp_start(dp_start),
      .dp_done (dp_done),
      .dp_xres (dp_xres),
      .dp_yres (dp_yres),
      .LED     (LED),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign dp_done = stub_done | stray_done;
   assign dp_xres = res_x;
   assign dp_yres = res_y;

   // Stub datapath: dp_done high in the third cycle after the dp_start cycle.
   initial begin
      stub_done = 1'b0;
      stub_cnt  = 0;
   end
   always @(posedge clk) begin
      stub_done <= 1'b0;
      if (dp_start === 1'b1 && stub_en) begin
         stub_cnt <= 2;
      end else if (stub_cnt != 0) begin
         if (stub_cnt == 1) stub_done <= 1'b1;
         stub_cnt <= stub_cnt - 1;
      end
   end

   initial start_cnt = 0;
   always @(negedge clk) if (dp_start === 1'b1) start_cnt++;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".dp_x"},   32'(dp_x),  32'(m_x));
      chk({tag, ".dp_y"},   32'(dp_y),  32'(m_y));
      chk({tag, ".led"},    32'(LED),   32'(m_led));
      chk({tag, ".err"},    32'(err),   32'(m_err));
      chk({tag, ".starts"}, 32'(start_cnt), 32'(m_starts));
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset  = 1'b1;
      sw_ack = 1'b0;
      wait_cyc(3);
      reset  = 1'b0;
      m_x    = '0;
      m_y    = '0;
      m_led  = '0;
      m_err  = 1'b0;
      m_step = 0;
      wait_cyc(1);
   endtask

   // Model steps: 0 want x, 1 x held, 2 want y, 3 y held, 4 showing x',
   // 5 showing y', 7 datapath running, 8 error (all switch events ignored).
   task automatic press(input logic [7:0] d, input string tag);
      sw_data = d;
      sw_ack  = 1'b1;
      wait_cyc(SETTLE);
      case (m_step)
         0: begin m_x = d; m_step = 1; end
         2: begin m_y = d; m_step = 3; end
         4: begin m_led = m_ry; m_step = 5; end
         default: ;
      endcase
      check_all(tag);
   endtask

   task automatic release_sw(input string tag);
      sw_ack = 1'b0;
      wait_cyc(SETTLE);
      case (m_step)
         1: m_step = 2;
         3: begin
            m_starts++;
            if (stub_en) begin
               m_led  = res_x;
               m_ry   = res_y;
               m_step = 4;
            end else begin
               m_step = 7;
            end
         end
         5: m_step = 0;
         default: ;
      endcase
      check_all(tag);
   endtask

   task automatic full_txn(input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] rx, input logic [7:0] ry, input string tag);
      res_x = rx;
      res_y = ry;
      press(x, {tag, ".px"});
      release_sw({tag, ".rx"});
      press(y, {tag, ".py"});
      release_sw({tag, ".ry"});
      press($urandom_range(0, 255), {tag, ".pshow"});
      release_sw({tag, ".rshow"});
   endtask

   initial begin
      int  cnt;
      bit  got;
      reset      = 1'b1;
      sw_ack     = 1'b0;
      sw_data    = '0;
      stray_done = 1'b0;
      stub_en    = 1'b1;
      res_x      = 8'h0B;
      res_y      = 8'hF4;
      m_ry       = '0;
      m_starts   = 0;
      n_cmp      = 0;
      n_bad      = 0;

      do_reset();
      check_all("reset");
      chk("reset.dp_start", 32'(dp_start), 32'd0);

      // Basic transaction with the fixed stub results, then show y' and return.
      full_txn(8'd10, 8'd4, 8'h0B, 8'hF4, "basic");

      // Signed extremes must be captured bit-exact.
      full_txn(8'h80, 8'h7F, 8'h55, 8'hAA, "extreme");

      for (int i = 0; i < 6; i++) begin
         full_txn(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), "rand");
      end

      // Datapath never completes: timeout measured from the dp_start cycle.
      stub_en = 1'b0;
      press(8'h21, "tmo.px");
      release_sw("tmo.rx");
      press(8'h42, "tmo.py");
      sw_ack = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         if (dp_start === 1'b1) got = 1'b1;
      end
      chk("tmo.start_seen", 32'(got), 32'd1);
      m_starts++;
      m_step = 7;
      cnt = 0;
      for (int i = 0; i < T + 20 && err !== 1'b1; i++) begin
         @(negedge clk);
         cnt++;
      end
      chk("tmo.cycles", 32'(cnt), 32'(T + 1));
      m_err  = 1'b1;
      m_led  = 8'hFF;
      m_step = 8;
      check_all("tmo.err");
      press(8'h99, "tmo.ignored_p");
      release_sw("tmo.ignored_r");
      do_reset();
      check_all("tmo.reset");

      // Stray completion while waiting for x must change nothing.
      stub_en = 1'b1;
      @(negedge clk);
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      wait_cyc(5);
      check_all("stray_done");
      press(8'h3C, "stray.px");
      release_sw("stray.rx");

      // Reset asserted while BUSY.
      stub_en = 1'b0;
      press(8'h5A, "busyrst.py");
      release_sw("busyrst.ry");
      do_reset();
      check_all("busyrst.reset");
      stub_en = 1'b1;
      full_txn(8'h12, 8'hED, 8'h0B, 8'hF4, "recover");

`ifdef DEBOUNCE_EN
      // A short glitch must be filtered out; a long press must be captured.
      @(negedge clk);
      sw_data = 8'h55;
      sw_ack  = 1'b1;
      wait_cyc(5);
      sw_ack  = 1'b0;
      wait_cyc(SETTLE);
      check_all("db.glitch");
      press(8'h66, "db.press");
      release_sw("db.rel");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
